// File: rtl/ch2_83_encoder_if.sv
// Bundle for the registered priority encoder: input vector A, index O, flag V.
// ERR exists only when ONEHOT_CHK_EN is defined; master drives A, slave drives O/V/ERR.
interface ch2_83_encoder_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 3
);

  logic [IN_W-1:0]  A;
  logic [OUT_W-1:0] O;
  logic             V;
`ifdef ONEHOT_CHK_EN
  logic             ERR;

  modport master (
    output A,
    input  O,
    input  V,
    input  ERR
  );

  modport slave (
    input  A,
    output O,
    output V,
    output ERR
  );
`else
  modport master (
    output A,
    input  O,
    input  V
  );

  modport slave (
    input  A,
    output O,
    output V
  );
`endif

endinterface

// File: rtl/ch2_83_encoder.sv
// Registered IN_W-to-OUT_W priority encoder (highest set bit wins), 1-cycle latency.
// Ports: clk, rst_n (sync, active-low), bus.slave (A in; O, V, ERR out). ERR needs ONEHOT_CHK_EN.
module ch2_83_encoder #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  ch2_83_encoder_if.slave bus
);

  logic [OUT_W-1:0] idx;
  logic             any;

  // Ascending scan: later (higher) set bits overwrite lower ones.
  always_comb begin
    idx = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (bus.A[i]) idx = OUT_W'(i);
    end
  end

  assign any = |bus.A;

`ifdef ONEHOT_CHK_EN
  logic multi;

  // Clearing the lowest set bit leaves
  // something only if 2+ bits were set.
  assign multi = |(bus.A & (bus.A - IN_W'(1)));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.O   <= '0;
      bus.V   <= 1'b0;
`ifdef ONEHOT_CHK_EN
      bus.ERR <= 1'b0;
`endif
    end else begin
      bus.O   <= idx;
      bus.V   <= any;
`ifdef ONEHOT_CHK_EN
      bus.ERR <= multi;
`endif
    end
  end

endmodule

// File: tb/tb_ch2_83_encoder.sv
// Scoreboard bench for ch2_83_encoder: directed cases then random A/rst_n.
// Expected values come from an arithmetic model (log2 of A, popcount).
module tb_ch2_83_encoder;

  logic clk;
  logic rst_n;

  ch2_83_encoder_if #(.IN_W(8), .OUT_W(3)) bus ();

  ch2_83_encoder #(.IN_W(8), .OUT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] a;
    logic [2:0] o;
    logic       v;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_chk;
  int   n_pass;

  // Highest set bit via arithmetic: floor(log2(a)) = clog2(a+1)-1.
  function automatic exp_t model(input logic [7:0] a, input logic rst,
                                 input int due);
    exp_t e;
    int   av;
    av    = int'(a);
    e.due = due;
    e.a   = a;
    if (!rst || av == 0) begin
      e.o = 3'd0;
    end else begin
      e.o = 3'($clog2(av + 1) - 1);
    end
    e.v   = rst && (av != 0);
    e.err = rst && ($countones(a) > 1);
    return e;
  endfunction

  task automatic drive(input logic [7:0] a, input logic rst, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      bus.A = a;
      rst_n = rst;
      q.push_back(model(a, rst, cyc + 1));
    end
  endtask

  // Monitor: checks every expectation due at this edge.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      while (q.size() > 0 && q[0].due <= cyc) begin
        exp_t e;
        logic ok;
        e  = q.pop_front();
        ok = (e.due == cyc) && (bus.O === e.o) && (bus.V === e.v);
`ifdef ONEHOT_CHK_EN
        ok = ok && (bus.ERR === e.err);
`endif
        n_chk++;
        if (ok) begin
          n_pass++;
        end else begin
`ifdef ONEHOT_CHK_EN
          $display("FAIL enc cyc=%0d A=%h: got O=%0d V=%0b ERR=%0b want O=%0d V=%0b ERR=%0b",
                   cyc, e.a, bus.O, bus.V, bus.ERR, e.o, e.v, e.err);
`else
          $display("FAIL enc cyc=%0d A=%h: got O=%0d V=%0b want O=%0d V=%0b",
                   cyc, e.a, bus.O, bus.V, e.o, e.v);
`endif
        end
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.A  = 8'hFF;

    // Reset dominates A=FF, then release.
    drive(8'hFF, 1'b0, 2);
    drive(8'hFF, 1'b1, 1);

    // Walking one, preceded by zero.
    drive(8'h00, 1'b1, 10);
    for (int b = 0; b < 8; b++) begin
      logic [7:0] w;
      w = 8'h01 << b;
      drive(w, 1'b1, 10);
    end

    // Zero vs bit 0.
    drive(8'h00, 1'b1, 2);
    drive(8'h01, 1'b1, 2);

    // Multi-hot priority.
    drive(8'b0010_0110, 1'b1, 2);
    drive(8'hFF, 1'b1, 2);

    // Reset mid-stream.
    drive(8'h40, 1'b1, 3);
    drive(8'h40, 1'b0, 1);
    drive(8'h40, 1'b1, 3);

    // Random, toggling every cycle, occasional reset.
    for (int k = 0; k < 400; k++) begin
      logic [7:0] r;
      logic       rs;
      r  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = 8'h01 << $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) r = 8'h00;
      rs = ($urandom_range(0, 19) != 0);
      drive(r, rs, 1);
    end

    // Drain with a bounded wait.
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
